// File: rtl/conv_window_buffer_if.sv
// -----------------------------------------------------------------------------
// conv_window_buffer_if
// Bus bundle for the convolution row-window buffer.
//   master : drives clr, ld, ld_row, ld_word, ld_data, shift_en, win_req,
//            col_idx; observes win_valid, win_miss, win_data, rows_ready.
//   slave  : the buffer side (mirror of master).
// -----------------------------------------------------------------------------
interface conv_window_buffer_if #(
  parameter int DW         = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 16,
  parameter int WORD_ELEMS = 4,
  parameter int WIN        = 4
);
  localparam int WORDS = COLS / WORD_ELEMS;
  localparam int RW    = (ROWS  > 1) ? $clog2(ROWS)  : 1;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW    = (COLS  > 1) ? $clog2(COLS)  : 1;

  logic                     clr;
  logic                     ld;
  logic [RW-1:0]            ld_row;
  logic [WW-1:0]            ld_word;
  logic [DW*WORD_ELEMS-1:0] ld_data;
  logic                     shift_en;
  logic                     win_req;
  logic [CW-1:0]            col_idx;
  logic                     win_valid;
  logic                     win_miss;
  logic [ROWS*WIN*DW-1:0]   win_data;
  logic                     rows_ready;

  modport master (
    output clr, ld, ld_row, ld_word, ld_data, shift_en, win_req, col_idx,
    input  win_valid, win_miss, win_data, rows_ready
  );

  modport slave (
    input  clr, ld, ld_row, ld_word, ld_data, shift_en, win_req, col_idx,
    output win_valid, win_miss, win_data, rows_ready
  );
endinterface

// File: rtl/conv_window_buffer.sv
// -----------------------------------------------------------------------------
// conv_window_buffer
// ROWS x COLS element buffer for the convolution datapath. Rows are loaded one
// packed word at a time, rotated upward to slide the filter vertically, and a
// registered ROWS x WIN window ending at col_idx is returned on request.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : conv_window_buffer_if.slave (load / shift / window request bus)
// Columns left of 0 either wrap modulo COLS (WRAP=1) or read as zero (WRAP=0).
// -----------------------------------------------------------------------------
module conv_window_buffer #(
  parameter int DW         = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 16,
  parameter int WORD_ELEMS = 4,
  parameter int WIN        = 4,
  parameter bit WRAP       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  conv_window_buffer_if.slave   bus
);
  localparam int WORDS = COLS / WORD_ELEMS;
  localparam int RW    = (ROWS  > 1) ? $clog2(ROWS)  : 1;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW    = (COLS  > 1) ? $clog2(COLS)  : 1;

  logic [ROWS-1:0][COLS-1:0][DW-1:0] mem_q, mem_d;
  logic [ROWS-1:0][WORDS-1:0]        fill_q, fill_d;
  logic [ROWS-1:0][WIN-1:0][DW-1:0]  win_s;
  logic [ROWS*WIN*DW-1:0]            win_data_q;
  logic                              win_valid_q;
  logic                              win_miss_q;
  logic                              ready_s;

  assign ready_s        = &fill_q;
  assign bus.rows_ready = ready_s;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_miss   = win_miss_q;
  assign bus.win_data   = win_data_q;

  // Next storage/fill state: clear wins, else shift first and then load into
  // the post-shift row (so a load to ROWS-1 refills the vacated row).
  always_comb begin
    mem_d  = mem_q;
    fill_d = fill_q;
    if (bus.clr) begin
      mem_d  = '0;
      fill_d = '0;
    end else begin
      if (bus.shift_en) begin
        for (int r = 0; r < ROWS - 1; r++) begin
          mem_d[r]  = mem_q[r+1];
          fill_d[r] = fill_q[r+1];
        end
        mem_d[ROWS-1]  = '0;
        fill_d[ROWS-1] = '0;
      end else begin
        mem_d = mem_d;
      end
      // Row match by comparison: an ld_row beyond ROWS-1 matches nothing.
      for (int r = 0; r < ROWS; r++) begin
        for (int w = 0; w < WORDS; w++) begin
          if (bus.ld && (bus.ld_row == RW'(r)) && (bus.ld_word == WW'(w))) begin
            for (int e = 0; e < WORD_ELEMS; e++) begin
              mem_d[r][w*WORD_ELEMS+e] = bus.ld_data[(WORD_ELEMS-1-e)*DW +: DW];
            end
            fill_d[r][w] = 1'b1;
          end else begin
            fill_d[r][w] = fill_d[r][w];
          end
        end
      end
    end
  end

  // Window gather from the current (pre-edge) contents; the subtraction wraps
  // naturally because COLS is a power of two, and the borrow flags c<0.
  always_comb begin
    logic [CW-1:0] ofs_s;
    logic [CW-1:0] col_s;
    logic          neg_s;
    win_s = '0;
    ofs_s = '0;
    col_s = '0;
    neg_s = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int k = 0; k < WIN; k++) begin
        ofs_s = CW'(WIN - 1 - k);
        col_s = bus.col_idx - ofs_s;
        neg_s = (bus.col_idx < ofs_s);
        if (neg_s && !WRAP) begin
          win_s[ROWS-1-r][WIN-1-k] = '0;
        end else begin
          win_s[ROWS-1-r][WIN-1-k] = mem_q[r][col_s];
        end
      end
    end
  end

  // State and registered window outputs; reset cancels any pending pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q       <= '0;
      fill_q      <= '0;
      win_valid_q <= 1'b0;
      win_miss_q  <= 1'b0;
      win_data_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      fill_q <= fill_d;
      if (bus.clr) begin
        win_valid_q <= 1'b0;
        win_miss_q  <= 1'b0;
      end else begin
        win_valid_q <= bus.win_req & ready_s;
        win_miss_q  <= bus.win_req & ~ready_s;
        if (bus.win_req && ready_s) begin
          win_data_q <= win_s;
        end else begin
          win_data_q <= win_data_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_window_buffer.sv
// -----------------------------------------------------------------------------
// tb_conv_window_buffer
// Drives a WRAP=1 and a WRAP=0 buffer with identical stimulus. Expected window
// responses come from an array model of the buffer and are queued per
// instance; a negedge monitor pops and compares whenever an output pulses.
// -----------------------------------------------------------------------------
module tb_conv_window_buffer;
  localparam int DW = 8, ROWS = 4, COLS = 16, WE = 4, WIN = 4;
  localparam int WORDS = COLS / WE;
  localparam int WD = ROWS * WIN * DW;

  typedef struct {
    bit            miss;
    logic [WD-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0, ld = 1'b0, shift_en = 1'b0, win_req = 1'b0;
  logic [1:0]  ld_row = 2'd0, ld_word = 2'd0;
  logic [31:0] ld_data = 32'd0;
  logic [3:0]  col_idx = 4'd0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]    mdl [ROWS][COLS];
  bit            fill [ROWS][WORDS];
  logic [WD-1:0] last1 = '0, last0 = '0;
  exp_t          q1[$];
  exp_t          q0[$];

  conv_window_buffer_if #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .WORD_ELEMS(WE), .WIN(WIN)) if1 ();
  conv_window_buffer_if #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .WORD_ELEMS(WE), .WIN(WIN)) if0 ();

  assign if1.clr = clr;       assign if0.clr = clr;
  assign if1.ld = ld;         assign if0.ld = ld;
  assign if1.ld_row = ld_row; assign if0.ld_row = ld_row;
  assign if1.ld_word = ld_word; assign if0.ld_word = ld_word;
  assign if1.ld_data = ld_data; assign if0.ld_data = ld_data;
  assign if1.shift_en = shift_en; assign if0.shift_en = shift_en;
  assign if1.win_req = win_req; assign if0.win_req = win_req;
  assign if1.col_idx = col_idx; assign if0.col_idx = col_idx;

  conv_window_buffer #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .WORD_ELEMS(WE), .WIN(WIN), .WRAP(1'b1))
    dut_wrap (.clk(clk), .rst(rst), .bus(if1));
  conv_window_buffer #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .WORD_ELEMS(WE), .WIN(WIN), .WRAP(1'b0))
    dut_zero (.clk(clk), .rst(rst), .bus(if0));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [WD-1:0] act, input logic [WD-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit mdl_ready();
    bit rdy = 1'b1;
    for (int r = 0; r < ROWS; r++)
      for (int w = 0; w < WORDS; w++)
        if (!fill[r][w]) rdy = 1'b0;
    return rdy;
  endfunction

  // Window from the model: column c = col-(WIN-1)+k, wrapped or zeroed when < 0.
  function automatic logic [WD-1:0] exp_win(input int col, input bit wrap);
    logic [WD-1:0] e = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int k = 0; k < WIN; k++) begin
        int c = col - (WIN - 1) + k;
        logic [7:0] v = 8'd0;
        if (c >= 0) v = mdl[r][c];
        else if (wrap) v = mdl[r][c + COLS];
        e[((ROWS - 1 - r) * WIN + (WIN - 1 - k)) * DW +: DW] = v;
      end
    end
    return e;
  endfunction

  task automatic mdl_clear();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) mdl[r][c] = 8'd0;
      for (int w = 0; w < WORDS; w++) fill[r][w] = 1'b0;
    end
  endtask

  // One clock of stimulus: predict, update the model, clock, queue the response.
  task automatic cyc(input bit c, input bit l, input int r, input int w,
                     input logic [31:0] d, input bit s, input bit q, input int col);
    exp_t e1, e0;
    bit   acc;
    clr = c; ld = l; ld_row = r[1:0]; ld_word = w[1:0]; ld_data = d;
    shift_en = s; win_req = q; col_idx = col[3:0];
    acc = q && !c;
    e1.miss = 1'b1; e1.data = last1;
    e0.miss = 1'b1; e0.data = last0;
    if (acc && mdl_ready()) begin
      e1.miss = 1'b0; e1.data = exp_win(col, 1'b1); last1 = e1.data;
      e0.miss = 1'b0; e0.data = exp_win(col, 1'b0); last0 = e0.data;
    end
    if (c) begin
      mdl_clear();
    end else begin
      if (s) begin
        for (int rr = 0; rr < ROWS - 1; rr++) begin
          for (int cc = 0; cc < COLS; cc++) mdl[rr][cc] = mdl[rr+1][cc];
          for (int ww = 0; ww < WORDS; ww++) fill[rr][ww] = fill[rr+1][ww];
        end
        for (int cc = 0; cc < COLS; cc++) mdl[ROWS-1][cc] = 8'd0;
        for (int ww = 0; ww < WORDS; ww++) fill[ROWS-1][ww] = 1'b0;
      end
      if (l) begin
        for (int e = 0; e < WE; e++) mdl[r][w*WE + e] = d[(WE - 1 - e) * 8 +: 8];
        fill[r][w] = 1'b1;
      end
    end
    @(posedge clk);
    if (acc) begin
      q1.push_back(e1);
      q0.push_back(e0);
    end
    #1;
    chk("rows_ready_wrap", if1.rows_ready, mdl_ready());
    chk("rows_ready_zero", if0.rows_ready, mdl_ready());
    clr = 1'b0; ld = 1'b0; shift_en = 1'b0; win_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 32'd0, 1'b0, 1'b0, 0);
  endtask

  task automatic ld_pattern(input int r, input int w);
    logic [31:0] d;
    for (int k = 0; k < WE; k++) d[(WE - 1 - k) * 8 +: 8] = {r[1:0], w[1:0], 4'(k)};
    cyc(1'b0, 1'b1, r, w, d, 1'b0, 1'b0, 0);
  endtask

  task automatic fill_random();
    for (int r = 0; r < ROWS; r++)
      for (int w = 0; w < WORDS; w++)
        cyc(1'b0, 1'b1, r, w, $urandom, 1'b0, 1'b0, 0);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_valid_wrap"}, if1.win_valid, 1'b0);
    chk({nm, "_miss_wrap"}, if1.win_miss, 1'b0);
    chk({nm, "_data_wrap"}, if1.win_data, '0);
    chk({nm, "_ready_wrap"}, if1.rows_ready, 1'b0);
    chk({nm, "_valid_zero"}, if0.win_valid, 1'b0);
    chk({nm, "_data_zero"}, if0.win_data, '0);
  endtask

  // Asynchronous reset applied between clock edges, with a response pending.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    q1.delete(); q0.delete();
    mdl_clear();
    last1 = '0; last0 = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic mon_one(input string nm, input logic v, input logic m,
                         input logic [WD-1:0] d, ref exp_t q[$]);
    exp_t e;
    if (v || m) begin
      if (q.size() == 0) begin
        chk({nm, "_unexpected_output"}, {v, m}, 2'b00);
      end else begin
        e = q.pop_front();
        chk({nm, "_kind"}, {v, m}, e.miss ? 2'b01 : 2'b10);
        chk({nm, "_data"}, d, e.data);
      end
    end else if (q.size() != 0) begin
      e = q.pop_front();
      chk({nm, "_missing_output"}, 1'b0, 1'b1);
    end
  endtask

  // Monitor: sample both buffers on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      mon_one("wrap", if1.win_valid, if1.win_miss, if1.win_data, q1);
      mon_one("zero", if0.win_valid, if0.win_miss, if0.win_data, q0);
    end
  end

  initial begin
    mdl_clear();
    #22;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Pattern fill; windows at col 7 and the wrap boundary col 1 / col 0.
    for (int r = 0; r < ROWS; r++)
      for (int w = 0; w < WORDS; w++) ld_pattern(r, w);
    cyc(1'b0, 1'b0, 0, 0, 32'd0, 1'b0, 1'b1, 7);
    cyc(1'b0, 1'b0, 0, 0, 32'd0, 1'b0, 1'b1, 1);
    cyc(1'b0, 1'b0, 0, 0, 32'd0, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b0, 0, 0, 32'd0, 1'b0, 1'b1, 15);

    // Shift alone drops readiness; the next request misses with data held.
    cyc(1'b0, 1'b0, 0, 0, 32'd0, 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b0, 0, 0, 32'd0, 1'b0, 1'b1, 9);

    // Shift + load to the vacated row in one cycle, then finish row 3.
    cyc(1'b0, 1'b1, 3, 2, 32'hAABBCCDD, 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b1, 3, 0, 32'h01020304, 1'b0, 1'b1, 11);
    cyc(1'b0, 1'b1, 3, 1, 32'h05060708, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b1, 3, 3, 32'h090A0B0C, 1'b0, 1'b0, 0);
    for (int c = 3; c < COLS; c += 4) cyc(1'b0, 1'b0, 0, 0, 32'd0, 1'b0, 1'b1, c);

    // Request and load of the same columns together: pre-load, then new data.
    cyc(1'b0, 1'b1, 0, 2, 32'h11223344, 1'b0, 1'b1, 11);
    cyc(1'b0, 1'b0, 0, 0, 32'd0, 1'b0, 1'b1, 11);

    // Async reset with a pending response, then refill and read back.
    cyc(1'b0, 1'b0, 0, 0, 32'd0, 1'b0, 1'b1, 5);
    async_reset();
    fill_random();
    for (int c = 0; c < COLS; c += 3) cyc(1'b0, 1'b0, 0, 0, 32'd0, 1'b0, 1'b1, c);

    // clr beats a same-cycle request; a following request misses, data held.
    cyc(1'b1, 1'b1, 1, 1, 32'hDEADBEEF, 1'b1, 1'b1, 4);
    cyc(1'b0, 1'b0, 0, 0, 32'd0, 1'b0, 1'b1, 4);
    fill_random();
    cyc(1'b0, 1'b0, 0, 0, 32'd0, 1'b0, 1'b1, 2);

    // Randomised traffic; shifts and clears kept rare so windows are served.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(99) == 0), ($urandom_range(2) != 0),
          int'($urandom_range(ROWS - 1)), int'($urandom_range(WORDS - 1)), $urandom,
          ($urandom_range(19) == 0), ($urandom_range(1) == 1),
          int'($urandom_range(COLS - 1)));
    end

    idle(3);
    chk("queue_drained_wrap", 32'(q1.size()), '0);
    chk("queue_drained_zero", 32'(q0.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_window_buffer.md
Name: conv_window_buffer

Overview:
Parametrised row-window buffer for the convolution datapath. It holds ROWS x COLS elements, loaded one packed word at a time from memory, and rotates rows upward to slide the filter vertically. On request it returns a registered ROWS x WIN element window ending at a column index. Compared with the fixed 4x16 buffer, it adds:
- generic sizes
- per-word fill tracking and a ready flag
- wrap or zero-pad column modes
- a defined simultaneous load+shift rule
- a request/valid output handshake

Parameters:
DW, 8, element width in bits
ROWS, 4, buffered rows (>=2)
COLS, 16, elements per row (multiple of WORD_ELEMS, power of 2)
WORD_ELEMS, 4, elements per load word
WIN, 4, window width in columns (1..COLS)
WRAP, 1, 1 = column index wraps modulo COLS; 0 = out-of-range columns read as zero

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
clr  in  1  synchronous clear of storage and fill state
ld  in  1  load strobe
ld_row  in  clog2(ROWS)  target row
ld_word  in  clog2(COLS/WORD_ELEMS)  target word slot in row
ld_data  in  DW*WORD_ELEMS  packed elements; MSB element goes to lowest column
shift_en  in  1  rotate rows up by one
win_req  in  1  window request strobe
col_idx  in  clog2(COLS)  rightmost window column
win_valid  out  1  window data valid, one-cycle pulse
win_miss  out  1  request rejected because buffer not ready, one-cycle pulse
win_data  out  ROWS*WIN*DW  window; row 0 most significant, within a row column col_idx-WIN+1 first
rows_ready  out  1  every word slot of every row filled

Behaviour:
- Reset (rst high, async): all elements cleared to 0; all fill bits cleared. Outputs: win_valid=0, win_miss=0, win_data=0, rows_ready=0.
- clr (sync): same clearing effect as reset, applied at the clock edge. clr has priority over ld, shift_en and win_req. win_data is held.
- Storage and fill state:
  - One fill bit per (row, word) slot.
  - rows_ready = AND of all fill bits. It is combinational from the registered fill bits.
- Load:
  - ld writes ld_data into row ld_row, columns ld_word*WORD_ELEMS .. +WORD_ELEMS-1, and sets that slot's fill bit.
  - Rewriting a filled slot overwrites the data; the fill bit stays set.
- Shift: shift_en moves row r+1 into row r for r = 0..ROWS-2, including fill bits. Row ROWS-1 becomes all zero with its fill bits cleared.
- Simultaneous ld and shift_en: the shift is applied first, then the load writes into the post-shift row ld_row.
  - Example: ld_row = ROWS-1 refills the freshly vacated row in the same cycle.
- Window access:
  - win_req with rows_ready=1: win_data is registered from the contents before this edge's ld/shift. win_valid=1 on the next cycle. Latency is 1.
  - win_req with rows_ready=0: win_miss=1 next cycle, win_valid=0, win_data held.
  - win_req accepted every cycle with no back-pressure; both pulses last one cycle.
- Column indexing: element k (k=0..WIN-1) of a row reads column c = col_idx-(WIN-1)+k.
  - WRAP=1: c is taken modulo COLS.
  - WRAP=0: c<0 yields 0.
- Out-of-range ld_row (ROWS not a power of 2): the write is ignored and no fill bit is set.
- Reset mid-operation: any pending win_valid/win_miss is cancelled immediately.

Test Plan:
1. Reset, then fill 16 words with ld (row r, word w, data {r,w,k} per element); after the last load, rows_ready=1. win_req with col_idx=7 -> next cycle win_valid=1; row0 slice = bytes at columns 4,5,6,7 of row 0.
2. WRAP=1, col_idx=1 -> row slice = columns 14,15,0,1. WRAP=0 (second instance), col_idx=1 -> 00,00,col0,col1.
3. shift_en alone -> row0 takes old row1 data; rows_ready drops to 0. win_req the next cycle -> win_miss=1, win_valid=0, win_data unchanged.
4. Same cycle shift_en + ld(row 3, word 2, 0xAABBCCDD) -> row2 = old row3, row3 columns 8..11 = AA,BB,CC,DD, other row3 columns 0. rows_ready=0 until the remaining 3 words are loaded, then 1.
5. win_req in the same cycle as ld to the window's columns -> window returns pre-load values. A request the following cycle returns new values.
6. Assert rst asynchronously mid-stream with a pending win_req -> win_valid=0 immediately; all window reads after refill match the new data only. clr gives the same result on the clock edge.
